tv80_bus_mem: RTL

- Parametrised Z80 bus responder that sits on the tv80s pin bus, replacing the ad-hoc mem/io arrays in CPU benches.
- Provides a memory space, an I/O register space, and a write-protected ROM region.
- Generates wait_n with programmable wait states (separate counts for memory and I/O).
- Answers interrupt-acknowledge cycles with a vector.
- Counts M1 fetches and write-protect violations for bench assertions.

---
 rtl/tv80_bus_mem.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/tv80_bus_mem.sv
// tv80_bus_mem: bus responder for the tv80s pin bus.
// Serves a memory space, an I/O register space and an interrupt vector.
// Inserts programmable wait states per access class. Blocks writes below ROM_TOP.
// Counts opcode fetches and blocked writes.
module tv80_bus_mem #(
    parameter int          ADDR_W   = 16,
    parameter int          IO_W     = 8,
    parameter logic [15:0] ROM_TOP  = 16'h0000,
    parameter int          MEM_WAIT = 0,
    parameter int          IO_WAIT  = 1,
    parameter int          M1_WAIT  = 0,
    parameter logic [7:0]  INT_VEC  = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] A,
    input  logic [7:0]  cpu_do,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    output logic [7:0]  di,
    output logic        wait_n,
    output logic [15:0] fetch_cnt,
    output logic        wp_err,
    output logic [7:0]  wp_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_HOLD} state_t;
    typedef enum logic [1:0] {C_MEM, C_IO, C_FETCH, C_INTA} cls_t;

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    logic [7:0] io  [0:(1<<IO_W)-1];

    state_t            state, state_nxt;
    cls_t              cls_now, cls_q, acc_cls;
    logic              wr_now, wr_q, acc_wr;
    logic              req;
    logic              go;
    logic              blocked;
    logic [3:0]        wcnt, wload;
    logic [15:0]       fetch_q;
    logic [ADDR_W-1:0] mem_addr;
    logic [IO_W-1:0]   io_addr;

    assign fetch_cnt = fetch_q;
    assign wait_n    = (state != S_WAIT);
    assign mem_addr  = A[ADDR_W-1:0];
    assign io_addr   = A[IO_W-1:0];

    // Decode the bus strobes into a request, its class, direction and wait count
    always_comb begin
        req = (!mreq_n && (!rd_n || !wr_n) && rfsh_n) ||
              (!iorq_n && (!rd_n || !wr_n)) ||
              (!m1_n && !iorq_n);
        cls_now = C_MEM;
        if (!m1_n && !mreq_n)
            cls_now = C_FETCH;
        else if (!m1_n && !iorq_n)
            cls_now = C_INTA;
        else if (!iorq_n)
            cls_now = C_IO;
        // rd_n and wr_n both low falls through to a write
        wr_now = !wr_n && (cls_now != C_INTA);
        case (cls_now)
            C_FETCH: wload = 4'(M1_WAIT);
            C_IO:    wload = 4'(IO_WAIT);
            C_INTA:  wload = 4'd0;
            default: wload = 4'(MEM_WAIT);
        endcase
    end

    // Zero-wait accesses transfer straight from IDLE, before the class is latched
    always_comb begin
        acc_cls = (state == S_IDLE) ? cls_now : cls_q;
        acc_wr  = (state == S_IDLE) ? wr_now  : wr_q;
        blocked = (acc_cls == C_MEM) && acc_wr && (A < ROM_TOP);
    end

    // Next-state logic; go marks the edge that enters ACCESS and performs the transfer
    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (wload == 4'd0) begin
                        state_nxt = S_ACCESS;
                        go        = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_nxt = S_IDLE;
                end else if (wcnt <= 4'd1) begin
                    state_nxt = S_ACCESS;
                    go        = 1'b1;
                end
            end
            S_ACCESS: state_nxt = S_HOLD;
            S_HOLD: begin
                if (!req)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Wait counter and latched class/direction of the cycle in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt  <= 4'd0;
            cls_q <= C_MEM;
            wr_q  <= 1'b0;
        end else if (state == S_IDLE && req) begin
            wcnt  <= wload;
            cls_q <= cls_now;
            wr_q  <= wr_now;
        end else if (state == S_WAIT) begin
            wcnt  <= wcnt - 4'd1;
        end
    end

    // Read data, fetch counter and write-protect reporting, updated only on a transfer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            di      <= 8'h00;
            fetch_q <= 16'h0000;
            wp_err  <= 1'b0;
            wp_cnt  <= 8'h00;
        end else begin
            wp_err <= 1'b0;
            if (go) begin
                if (!acc_wr) begin
                    case (acc_cls)
                        C_IO:    di <= io[io_addr];
                        C_INTA:  di <= INT_VEC;
                        default: di <= mem[mem_addr];
                    endcase
                end
                if (acc_cls == C_FETCH)
                    fetch_q <= fetch_q + 16'd1;
                if (blocked) begin
                    wp_err <= 1'b1;
                    if (wp_cnt != 8'hFF)
                        wp_cnt <= wp_cnt + 8'd1;
                end
            end
        end
    end

    // Array writes; storage is never cleared, and reset cancels a write on the same edge
    always_ff @(posedge clk) begin
        if (go && acc_wr && !reset) begin
            if (acc_cls == C_IO)
                io[io_addr] <= cpu_do;
            else if (acc_cls == C_MEM && !blocked)
                mem[mem_addr] <= cpu_do;
        end
    end

endmodule
